// File: rtl/camera64x64_reader.sv
// SPI mode-0 readout master for the 64x64 camera: waits for INT, then clocks in
// PIXELS x PIX_BITS bits MSB first and strobes each completed pixel downstream.
module camera64x64_reader #(
  parameter int          CLK_DIV  = 4,
  parameter int          PIX_BITS = 8,
  parameter int          PIXELS   = 4096,
  parameter int          ADDR_W   = 12,
  parameter logic [31:0] TIMEOUT  = 32'd200000
) (
  input  logic                CLK,
  input  logic                RST,
  input  logic                START,
  input  logic                INT,
  input  logic                MISO,
  output logic                SCLK,
  output logic                CS_N,
  output logic                BUSY,
  output logic                PIX_VALID,
  output logic [PIX_BITS-1:0] PIX_DATA,
  output logic [ADDR_W-1:0]   PIX_ADDR,
  output logic                DONE,
  output logic                ERR
);

  localparam int DIV_W = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
  localparam int BIT_W = $clog2(PIX_BITS);

  localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(CLK_DIV - 1);
  localparam logic [BIT_W-1:0] BIT_LAST = BIT_W'(PIX_BITS - 1);
  localparam logic [ADDR_W:0]  PIX_END  = (ADDR_W + 1)'(PIXELS);
  localparam logic [31:0]      TMO_LAST = TIMEOUT - 32'd1;

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    WAIT_INT = 2'd1,
    SHIFT    = 2'd2,
    FINISH   = 2'd3
  } state_t;

  state_t              state_q;
  logic [DIV_W-1:0]    div_q;
  logic [BIT_W-1:0]    bit_q;
  logic [ADDR_W:0]     pix_q;
  logic [31:0]         tmo_q;
  logic [PIX_BITS-1:0] shift_q;
  logic                sclk_q;
  logic                cs_n_q;
  logic                busy_q;
  logic                pix_valid_q;
  logic [PIX_BITS-1:0] pix_data_q;
  logic [ADDR_W-1:0]   pix_addr_q;
  logic                done_q;
  logic                err_q;

  // Frame sequencer, SPI clock generator and pixel assembler.
  always_ff @(posedge CLK) begin
    if (RST) begin
      state_q     <= IDLE;
      div_q       <= '0;
      bit_q       <= '0;
      pix_q       <= '0;
      tmo_q       <= 32'd0;
      shift_q     <= '0;
      sclk_q      <= 1'b0;
      cs_n_q      <= 1'b1;
      busy_q      <= 1'b0;
      pix_valid_q <= 1'b0;
      pix_data_q  <= '0;
      pix_addr_q  <= '0;
      done_q      <= 1'b0;
      err_q       <= 1'b0;
    end else begin
      pix_valid_q <= 1'b0;
      done_q      <= 1'b0;
      err_q       <= 1'b0;
      case (state_q)
        IDLE: begin
          if (START) begin
            state_q <= WAIT_INT;
            busy_q  <= 1'b1;
            tmo_q   <= 32'd0;
          end
        end
        WAIT_INT: begin
          if (INT) begin
            state_q <= SHIFT;
            cs_n_q  <= 1'b0;
            div_q   <= '0;
            bit_q   <= '0;
            pix_q   <= '0;
          end else if (tmo_q == TMO_LAST) begin
            state_q <= IDLE;
            err_q   <= 1'b1;
            busy_q  <= 1'b0;
          end else begin
            tmo_q <= tmo_q + 32'd1;
          end
        end
        SHIFT: begin
          if (div_q == DIV_LAST) begin
            div_q <= '0;
            if (!sclk_q) begin
              // Rising edge: camera data is stable, capture it.
              sclk_q  <= 1'b1;
              shift_q <= {shift_q[PIX_BITS-2:0], MISO};
              if (bit_q == BIT_LAST) begin
                pix_data_q  <= {shift_q[PIX_BITS-2:0], MISO};
                pix_addr_q  <= pix_q[ADDR_W-1:0];
                pix_valid_q <= 1'b1;
                bit_q       <= '0;
                pix_q       <= pix_q + (ADDR_W + 1)'(1);
              end else begin
                bit_q <= bit_q + BIT_W'(1);
              end
            end else begin
              sclk_q <= 1'b0;
              if (pix_q == PIX_END) begin
                state_q <= FINISH;
                done_q  <= 1'b1;
              end
            end
          end else begin
            div_q <= div_q + DIV_W'(1);
          end
        end
        FINISH: begin
          cs_n_q  <= 1'b1;
          busy_q  <= 1'b0;
          state_q <= IDLE;
        end
        default: begin
          state_q <= IDLE;
        end
      endcase
    end
  end

  assign SCLK      = sclk_q;
  assign CS_N      = cs_n_q;
  assign BUSY      = busy_q;
  assign PIX_VALID = pix_valid_q;
  assign PIX_DATA  = pix_data_q;
  assign PIX_ADDR  = pix_addr_q;
  assign DONE      = done_q;
  assign ERR       = err_q;

endmodule

// File: tb/tb_camera64x64_reader.sv
// Directed bench for camera64x64_reader: three instances cover the normal frame,
// the INT timeout and the fastest SPI clock configuration.
module tb_camera64x64_reader;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  int errors = 0;
  int checks = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Instance A: CLK_DIV=2, 4 pixels, generous timeout.
  logic rst_a, start_a, int_a, miso_a, sclk_a, cs_n_a, busy_a, pv_a, done_a, err_a;
  logic [7:0] pd_a;
  logic [1:0] pa_a;
  camera64x64_reader #(.CLK_DIV(2), .PIX_BITS(8), .PIXELS(4), .ADDR_W(2), .TIMEOUT(32'd1000)) dut_a (
    .CLK(clk), .RST(rst_a), .START(start_a), .INT(int_a), .MISO(miso_a),
    .SCLK(sclk_a), .CS_N(cs_n_a), .BUSY(busy_a), .PIX_VALID(pv_a),
    .PIX_DATA(pd_a), .PIX_ADDR(pa_a), .DONE(done_a), .ERR(err_a));

  // Instance B: TIMEOUT=10, INT never asserted.
  logic rst_b, start_b, int_b, miso_b, sclk_b, cs_n_b, busy_b, pv_b, done_b, err_b;
  logic [7:0] pd_b;
  logic [1:0] pa_b;
  camera64x64_reader #(.CLK_DIV(2), .PIX_BITS(8), .PIXELS(4), .ADDR_W(2), .TIMEOUT(32'd10)) dut_b (
    .CLK(clk), .RST(rst_b), .START(start_b), .INT(int_b), .MISO(miso_b),
    .SCLK(sclk_b), .CS_N(cs_n_b), .BUSY(busy_b), .PIX_VALID(pv_b),
    .PIX_DATA(pd_b), .PIX_ADDR(pa_b), .DONE(done_b), .ERR(err_b));

  // Instance C: CLK_DIV=1, 2 pixels.
  logic rst_c, start_c, int_c, miso_c, sclk_c, cs_n_c, busy_c, pv_c, done_c, err_c;
  logic [7:0] pd_c;
  logic [0:0] pa_c;
  camera64x64_reader #(.CLK_DIV(1), .PIX_BITS(8), .PIXELS(2), .ADDR_W(1), .TIMEOUT(32'd1000)) dut_c (
    .CLK(clk), .RST(rst_c), .START(start_c), .INT(int_c), .MISO(miso_c),
    .SCLK(sclk_c), .CS_N(cs_n_c), .BUSY(busy_c), .PIX_VALID(pv_c),
    .PIX_DATA(pd_c), .PIX_ADDR(pa_c), .DONE(done_c), .ERR(err_c));

  // One frame on instance A; optionally late INT, START spam, or a reset during pixel 2.
  task automatic run_frame_a(input int int_delay, input bit spam, input bit do_rst);
    logic [7:0] bytes [4];
    int cs_cyc, done_cyc, rises, npix, ndone, nerr, exp_cs;
    bit sclk_prev;
    bytes = '{8'hA5, 8'h3C, 8'hFF, 8'h00};
    cs_cyc = -1; done_cyc = -1; rises = 0; npix = 0; ndone = 0; nerr = 0; sclk_prev = 1'b0;
    int_a = (int_delay == 0);
    start_a = 1'b1;
    @(negedge clk);
    start_a = 1'b0;
    for (int cyc = 1; cyc < 600; cyc++) begin
      if (cyc == 1) check("busy_after_start", busy_a, 1);
      if (!cs_n_a && cs_cyc < 0) cs_cyc = cyc;
      if (sclk_a && !sclk_prev) rises++;
      sclk_prev = sclk_a;
      if (pv_a) begin
        if (npix < 4) begin
          check("pix_data", pd_a, bytes[npix]);
          check("pix_addr", pa_a, npix);
        end
        npix++;
      end
      if (done_a) begin
        ndone++;
        done_cyc = cyc;
      end
      if (err_a) nerr++;
      if (do_rst && npix == 2) begin
        rst_a = 1'b1;
        @(negedge clk);
        rst_a = 1'b0;
        check("rst_ctrl", {sclk_a, cs_n_a, busy_a, pv_a, done_a, err_a}, 6'b010000);
        check("rst_data", pd_a, 0);
        check("rst_addr", pa_a, 0);
        ndone = 0;
        for (int k = 0; k < 40; k++) begin
          @(negedge clk);
          if (done_a || err_a || !cs_n_a) ndone++;
        end
        check("rst_quiet", ndone, 0);
        return;
      end
      if (done_cyc > 0 && cyc == done_cyc + 1) begin
        check("idle_after_done", {cs_n_a, sclk_a, busy_a}, 3'b100);
        break;
      end
      if (!sclk_a) miso_a = (rises < 32) ? bytes[rises / 8][7 - rises % 8] : 1'b0;
      int_a = (cyc >= int_delay);
      if (spam) start_a = (npix < 3) && (cs_cyc > 0) && (cyc % 3 == 0);
      @(negedge clk);
    end
    start_a = 1'b0;
    exp_cs = (int_delay == 0) ? 2 : int_delay + 1;
    check("cs_fall_cycle", cs_cyc, exp_cs);
    check("rise_count", rises, 32);
    check("pix_count", npix, 4);
    check("done_count", ndone, 1);
    check("no_err", nerr, 0);
    check("done_latency", done_cyc - cs_cyc, 128);
  endtask

  initial begin
    int err_cyc, nerr, sclk_hi, cs_lo, rises, npix, cs_cyc, done_cyc, last_rise;
    logic [7:0] cbytes [2];
    bit sclk_prev;
    cbytes = '{8'h5A, 8'hC3};
    rst_a = 1'b1; start_a = 1'b0; int_a = 1'b0; miso_a = 1'b0;
    rst_b = 1'b1; start_b = 1'b0; int_b = 1'b0; miso_b = 1'b0;
    rst_c = 1'b1; start_c = 1'b0; int_c = 1'b1; miso_c = 1'b0;
    repeat (3) @(negedge clk);
    rst_a = 1'b0; rst_b = 1'b0; rst_c = 1'b0;
    check("reset_ctrl", {sclk_a, cs_n_a, busy_a, pv_a, done_a, err_a}, 6'b010000);
    check("reset_data", {pd_a, pa_a}, 0);
    @(negedge clk);

    run_frame_a(0, 1'b0, 1'b0);
    repeat (3) @(negedge clk);
    run_frame_a(50, 1'b0, 1'b0);
    repeat (3) @(negedge clk);
    run_frame_a(0, 1'b1, 1'b0);
    repeat (3) @(negedge clk);
    run_frame_a(0, 1'b0, 1'b1);
    run_frame_a(0, 1'b0, 1'b0);
    repeat (3) @(negedge clk);

    // RST and START together: reset wins.
    start_a = 1'b1; rst_a = 1'b1;
    @(negedge clk);
    start_a = 1'b0; rst_a = 1'b0;
    check("rst_beats_start", busy_a, 0);
    @(negedge clk);
    check("rst_beats_start_2", busy_a, 0);

    // Timeout on instance B.
    err_cyc = -1; nerr = 0; sclk_hi = 0; cs_lo = 0;
    start_b = 1'b1;
    @(negedge clk);
    start_b = 1'b0;
    for (int cyc = 1; cyc <= 40; cyc++) begin
      if (err_b && err_cyc < 0) err_cyc = cyc;
      if (err_b) nerr++;
      if (sclk_b) sclk_hi++;
      if (!cs_n_b) cs_lo++;
      if (cyc == 10) check("tmo_busy_before", busy_b, 1);
      if (cyc == 11) check("tmo_busy_after", busy_b, 0);
      @(negedge clk);
    end
    check("tmo_err_cycle", err_cyc, 11);
    check("tmo_err_count", nerr, 1);
    check("tmo_sclk_idle", sclk_hi, 0);
    check("tmo_cs_idle", cs_lo, 0);

    // Fastest SPI clock on instance C.
    rises = 0; npix = 0; cs_cyc = -1; done_cyc = -1; last_rise = -1; sclk_prev = 1'b0;
    start_c = 1'b1;
    @(negedge clk);
    start_c = 1'b0;
    for (int cyc = 1; cyc < 200; cyc++) begin
      if (!cs_n_c && cs_cyc < 0) cs_cyc = cyc;
      if (sclk_c && !sclk_prev) begin
        if (last_rise > 0) check("c_sclk_period", cyc - last_rise, 2);
        last_rise = cyc;
        rises++;
      end
      sclk_prev = sclk_c;
      if (pv_c) begin
        if (npix < 2) begin
          check("c_pix_data", pd_c, cbytes[npix]);
          check("c_pix_addr", pa_c, npix);
        end
        npix++;
      end
      if (done_c && done_cyc < 0) done_cyc = cyc;
      if (done_cyc > 0 && cyc > done_cyc + 2) break;
      if (!sclk_c) miso_c = (rises < 16) ? cbytes[rises / 8][7 - rises % 8] : 1'b0;
      @(negedge clk);
    end
    check("c_rise_count", rises, 16);
    check("c_pix_count", npix, 2);
    check("c_done_latency", done_cyc - cs_cyc, 32);
    check("c_idle", {cs_n_c, sclk_c, busy_c}, 3'b100);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
